rv32i_trap_sequencer: RTL and testbench
=======================================

Name: rv32i_trap_sequencer

Overview:
Controller that arbitrates trap and return requests and sequences them into rv32i_csr_single_stage_pipeline. The sources are the three machine interrupt lines, the decode exception flags and mret. It selects one winner per accepted instruction and captures its cause and return PC. It then stalls and flushes the pipeline for a fixed drain window before issuing a one-cycle trap or return strobe to the CSR unit. It sits between decode/issue and the CSR unit.

Parameters:
FLUSH_CYCLES, 2, number of drain cycles with o_flush high before the trap strobe; legal range 1..15.

Ports:
i_clk  input  1  clock, rising edge.
i_rst  input  1  synchronous reset, active-high.
i_ce  input  1  instruction at i_pc is valid and issuing this cycle.
i_pc  input  32  PC of the issuing instruction.
i_is_inst_illegal  input  1  illegal-instruction flag, qualified by i_ce.
i_is_ecall  input  1  ecall flag, qualified by i_ce.
i_is_ebreak  input  1  ebreak flag, qualified by i_ce.
i_is_mret  input  1  mret flag, qualified by i_ce.
i_external_interrupt  input  1  level machine external interrupt.
i_software_interrupt  input  1  level machine software interrupt.
i_timer_interrupt  input  1  level machine timer interrupt.
i_mstatus_mie  input  1  global interrupt enable from the CSR unit.
i_mie_meie  input  1  external-interrupt enable.
i_mie_msie  input  1  software-interrupt enable.
i_mie_mtie  input  1  timer-interrupt enable.
o_stall  output  1  freezes fetch/issue; high whenever state != IDLE.
o_flush  output  1  kills in-flight instructions; high in DRAIN and RETURN.
o_go_to_trap  output  1  one-cycle strobe to the CSR unit: enter trap.
o_return_from_trap  output  1  one-cycle strobe to the CSR unit: execute mret.
o_mcause  output  32  captured cause; valid from DRAIN through TRAP.
o_mepc  output  32  captured return PC; valid from DRAIN through TRAP.

Behaviour:
- All outputs are registered. Reset drives every output to 0, state to IDLE, the drain counter to 0 and the holdoff flag to 0.
- Reset asserted in any state aborts the sequence on that edge. No strobe is emitted afterwards.
- States are IDLE, DRAIN, TRAP and RETURN.
- IDLE evaluates only when i_ce=1. Priority from highest:
  1. Exception: illegal (cause 0x00000002), then ecall (0x0000000B), then ebreak (0x00000003).
  2. Interrupt. It is eligible only if i_mstatus_mie=1 and holdoff=0. Among eligible interrupts: external (0x8000000B), then software (0x80000003), then timer (0x80000007). Each requires its own enable and line to be 1.
  3. mret.
- Exception or interrupt winner: latch o_mcause and o_mepc=i_pc, go to DRAIN. For an interrupt, mepc is the PC of the not-yet-executed instruction.
- mret winner: go to RETURN.
- No winner, or i_ce=0: stay in IDLE.
- Simultaneous mret and exception: the exception wins and mret is discarded.
- Simultaneous mret and an eligible interrupt: the interrupt wins.
- DRAIN: o_stall=1 and o_flush=1. The counter counts 0..FLUSH_CYCLES-1, then the state moves to TRAP.
- TRAP: lasts 1 cycle, with o_go_to_trap=1, o_stall=1 and o_flush=0. Next state is IDLE with holdoff set.
- RETURN: lasts 1 cycle, with o_return_from_trap=1, o_stall=1 and o_flush=1. Next state is IDLE with holdoff set.
- Holdoff blocks interrupt acceptance for exactly the first IDLE cycle after TRAP/RETURN, so the CSR unit's MIE update becomes visible. It clears after that cycle. Exceptions and mret are not blocked by holdoff.
- Interrupt lines and request flags are ignored outside IDLE. No pending state is stored: interrupts are level-sensitive and re-sampled in IDLE.
- Latency: accept on edge k. o_flush is high in cycles k+1..k+FLUSH_CYCLES. o_go_to_trap is high in cycle k+FLUSH_CYCLES+1. o_stall falls in cycle k+FLUSH_CYCLES+2.
- o_go_to_trap and o_return_from_trap are never high together and are never high for two consecutive cycles.

Test Plan:
- Reset: hold i_rst=1 for 2 cycles with all inputs random -> all outputs 0 and state IDLE. Release, i_ce=0 for 5 cycles -> outputs stay 0.
- ecall: i_ce=1, i_is_ecall=1, i_pc=0x00000100 at edge k with FLUSH_CYCLES=2 -> o_flush high in k+1 and k+2. o_go_to_trap high in k+3 only, with o_mcause=0x0000000B and o_mepc=0x00000100. o_stall low from k+4.
- Interrupt priority: external, software and timer lines all 1, all enables 1, i_mstatus_mie=1, i_pc=0x00000200 -> o_mcause=0x8000000B and o_mepc=0x00000200. The same test with i_mie_meie=0 -> o_mcause=0x80000003.
- Masking and holdoff: i_timer_interrupt=1 with i_mstatus_mie=0 -> no trap for 10 cycles. Then i_is_mret with i_mstatus_mie forced to 1 -> o_return_from_trap pulses 1 cycle. The interrupt is not taken in the holdoff cycle; it is accepted in the following cycle with o_mcause=0x80000007.
- Simultaneous events: i_is_inst_illegal=1, i_is_mret=1 and an eligible external interrupt in the same i_ce cycle -> o_mcause=0x00000002 and no o_return_from_trap.
- Reset mid-sequence: accept ebreak, assert i_rst in the first DRAIN cycle -> next cycle all outputs 0. No o_go_to_trap ever appears.

Source files
------------

// File: rtl/rv32i_trap_sequencer.sv
// Trap/return sequencer: arbitrates exceptions, interrupts and mret, drains the
// pipeline for FLUSH_CYCLES, then strobes the CSR unit for one cycle.
module rv32i_trap_sequencer #(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_ce,
  input  logic [31:0] i_pc,
  input  logic        i_is_inst_illegal,
  input  logic        i_is_ecall,
  input  logic        i_is_ebreak,
  input  logic        i_is_mret,
  input  logic        i_external_interrupt,
  input  logic        i_software_interrupt,
  input  logic        i_timer_interrupt,
  input  logic        i_mstatus_mie,
  input  logic        i_mie_meie,
  input  logic        i_mie_msie,
  input  logic        i_mie_mtie,
  output logic        o_stall,
  output logic        o_flush,
  output logic        o_go_to_trap,
  output logic        o_return_from_trap,
  output logic [31:0] o_mcause,
  output logic [31:0] o_mepc
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DRAIN  = 2'd1;
  localparam logic [1:0] S_TRAP   = 2'd2;
  localparam logic [1:0] S_RETURN = 2'd3;

  localparam logic [3:0] CNT_LAST = 4'(FLUSH_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        holdoff_q, holdoff_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] mepc_q, mepc_d;
  logic        stall_q, flush_q, trap_q, ret_q;

  logic        exc_v, irq_v, irq_ok;
  logic [31:0] exc_cause, irq_cause;

  always_comb begin
    exc_v     = 1'b1;
    exc_cause = 32'h0;
    if (i_is_inst_illegal)  exc_cause = 32'h0000_0002;
    else if (i_is_ecall)    exc_cause = 32'h0000_000B;
    else if (i_is_ebreak)   exc_cause = 32'h0000_0003;
    else                    exc_v     = 1'b0;

    // Holdoff gives the CSR unit one cycle to publish its new MIE value.
    irq_ok    = i_mstatus_mie & ~holdoff_q;
    irq_v     = 1'b1;
    irq_cause = 32'h0;
    if (irq_ok & i_external_interrupt & i_mie_meie)      irq_cause = 32'h8000_000B;
    else if (irq_ok & i_software_interrupt & i_mie_msie) irq_cause = 32'h8000_0003;
    else if (irq_ok & i_timer_interrupt & i_mie_mtie)    irq_cause = 32'h8000_0007;
    else                                                 irq_v     = 1'b0;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    holdoff_d = holdoff_q;
    mcause_d  = mcause_q;
    mepc_d    = mepc_q;
    case (state_q)
      S_IDLE: begin
        holdoff_d = 1'b0;
        if (i_ce) begin
          if (exc_v) begin
            mcause_d = exc_cause;
            mepc_d   = i_pc;
            cnt_d    = 4'd0;
            state_d  = S_DRAIN;
          end else if (irq_v) begin
            mcause_d = irq_cause;
            mepc_d   = i_pc;
            cnt_d    = 4'd0;
            state_d  = S_DRAIN;
          end else if (i_is_mret) begin
            state_d  = S_RETURN;
          end
        end
      end
      S_DRAIN: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = 4'd0;
          state_d = S_TRAP;
        end else begin
          cnt_d   = cnt_q + 4'd1;
        end
      end
      S_TRAP, S_RETURN: begin
        holdoff_d = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with state_q.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      holdoff_q <= 1'b0;
      mcause_q  <= 32'h0;
      mepc_q    <= 32'h0;
      stall_q   <= 1'b0;
      flush_q   <= 1'b0;
      trap_q    <= 1'b0;
      ret_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      holdoff_q <= holdoff_d;
      mcause_q  <= mcause_d;
      mepc_q    <= mepc_d;
      stall_q   <= (state_d != S_IDLE);
      flush_q   <= (state_d == S_DRAIN) || (state_d == S_RETURN);
      trap_q    <= (state_d == S_TRAP);
      ret_q     <= (state_d == S_RETURN);
    end
  end

  assign o_stall            = stall_q;
  assign o_flush            = flush_q;
  assign o_go_to_trap       = trap_q;
  assign o_return_from_trap = ret_q;
  assign o_mcause           = mcause_q;
  assign o_mepc             = mepc_q;

endmodule

// File: tb/tb_rv32i_trap_sequencer.sv
// Bench for rv32i_trap_sequencer: directed vector table, hand-written corner
// sequences and random stimulus against a timeline-based reference model.
module tb_rv32i_trap_sequencer;

  localparam int FC = 2;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_ce = 1'b0;
  logic [31:0] i_pc = 32'h0;
  logic        i_is_inst_illegal = 1'b0, i_is_ecall = 1'b0, i_is_ebreak = 1'b0, i_is_mret = 1'b0;
  logic        i_external_interrupt = 1'b0, i_software_interrupt = 1'b0, i_timer_interrupt = 1'b0;
  logic        i_mstatus_mie = 1'b0, i_mie_meie = 1'b0, i_mie_msie = 1'b0, i_mie_mtie = 1'b0;
  logic        o_stall, o_flush, o_go_to_trap, o_return_from_trap;
  logic [31:0] o_mcause, o_mepc;

  rv32i_trap_sequencer #(.FLUSH_CYCLES(FC)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_ce(i_ce), .i_pc(i_pc),
    .i_is_inst_illegal(i_is_inst_illegal), .i_is_ecall(i_is_ecall),
    .i_is_ebreak(i_is_ebreak), .i_is_mret(i_is_mret),
    .i_external_interrupt(i_external_interrupt),
    .i_software_interrupt(i_software_interrupt),
    .i_timer_interrupt(i_timer_interrupt),
    .i_mstatus_mie(i_mstatus_mie), .i_mie_meie(i_mie_meie),
    .i_mie_msie(i_mie_msie), .i_mie_mtie(i_mie_mtie),
    .o_stall(o_stall), .o_flush(o_flush), .o_go_to_trap(o_go_to_trap),
    .o_return_from_trap(o_return_from_trap), .o_mcause(o_mcause), .o_mepc(o_mepc)
  );

  always #5 i_clk = ~i_clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: ph counts cycles since acceptance (0 = idle).
  int          ph = 0;
  bit          kret = 1'b0;
  bit          hold = 1'b0;
  logic [31:0] mc = 32'h0, me = 32'h0;

  task automatic model_update();
    bit h;
    int last;
    if (i_rst) begin
      ph = 0; kret = 1'b0; hold = 1'b0; mc = 32'h0; me = 32'h0;
    end else if (ph == 0) begin
      h    = hold;
      hold = 1'b0;
      if (i_ce) begin
        if (i_is_inst_illegal)      begin ph = 1; kret = 0; mc = 32'h2; me = i_pc; end
        else if (i_is_ecall)        begin ph = 1; kret = 0; mc = 32'hB; me = i_pc; end
        else if (i_is_ebreak)       begin ph = 1; kret = 0; mc = 32'h3; me = i_pc; end
        else if (i_mstatus_mie && !h && i_external_interrupt && i_mie_meie)
                                    begin ph = 1; kret = 0; mc = 32'h8000000B; me = i_pc; end
        else if (i_mstatus_mie && !h && i_software_interrupt && i_mie_msie)
                                    begin ph = 1; kret = 0; mc = 32'h80000003; me = i_pc; end
        else if (i_mstatus_mie && !h && i_timer_interrupt && i_mie_mtie)
                                    begin ph = 1; kret = 0; mc = 32'h80000007; me = i_pc; end
        else if (i_is_mret)         begin ph = 1; kret = 1; end
      end
    end else begin
      last = kret ? 1 : FC + 1;
      if (ph == last) begin ph = 0; hold = 1'b1; end
      else ph++;
    end
  endtask

  function automatic logic [3:0] model_ctl();
    logic st, fl, tr, rt;
    st = (ph != 0);
    fl = (ph != 0) && (kret || ph <= FC);
    tr = !kret && (ph == FC + 1);
    rt = kret && (ph == 1);
    return {st, fl, tr, rt};
  endfunction

  task automatic cmp(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [67:0] dut_vec();
    return {o_stall, o_flush, o_go_to_trap, o_return_from_trap, o_mcause, o_mepc};
  endfunction

  task automatic tick(input string name);
    @(posedge i_clk);
    #1;
    model_update();
    cmp({name, "/model"}, 96'(dut_vec()), 96'({model_ctl(), mc, me}));
  endtask

  typedef struct {
    logic        rst, ce;
    logic [31:0] pc;
    logic [3:0]  req;   // {illegal, ecall, ebreak, mret}
    logic [2:0]  irq;   // {external, software, timer}
    logic        mie;
    logic [2:0]  en;    // {meie, msie, mtie}
    logic [3:0]  ctl;   // {stall, flush, trap, return}
    logic [31:0] cause, epc;
  } vec_t;

  vec_t tbl[26];

  function automatic vec_t mk(logic rst, logic ce, logic [31:0] pc, logic [3:0] req,
                              logic [2:0] irq, logic mie, logic [2:0] en,
                              logic [3:0] ctl, logic [31:0] cause, logic [31:0] epc);
    vec_t v;
    v.rst = rst; v.ce = ce; v.pc = pc; v.req = req; v.irq = irq; v.mie = mie;
    v.en = en; v.ctl = ctl; v.cause = cause; v.epc = epc;
    return v;
  endfunction

  task automatic drive(input logic rst, input logic ce, input logic [31:0] pc,
                       input logic [3:0] req, input logic [2:0] irq,
                       input logic mie, input logic [2:0] en);
    i_rst = rst; i_ce = ce; i_pc = pc;
    {i_is_inst_illegal, i_is_ecall, i_is_ebreak, i_is_mret} = req;
    {i_external_interrupt, i_software_interrupt, i_timer_interrupt} = irq;
    i_mstatus_mie = mie;
    {i_mie_meie, i_mie_msie, i_mie_mtie} = en;
  endtask

  initial begin
    tbl[0]  = mk(1, 0, 32'h0,   4'b0000, 3'b000, 0, 3'b000, 4'b0000, 32'h0, 32'h0);
    tbl[1]  = mk(1, 1, 32'h100, 4'b0100, 3'b111, 1, 3'b111, 4'b0000, 32'h0, 32'h0);
    for (int i = 2; i <= 6; i++)
      tbl[i] = mk(0, 0, 32'h0, 4'b0000, 3'b000, 0, 3'b000, 4'b0000, 32'h0, 32'h0);
    // ecall at edge k: flush k+1..k+2, trap k+3, stall low k+4
    tbl[7]  = mk(0, 1, 32'h100, 4'b0100, 3'b000, 0, 3'b000, 4'b1100, 32'hB, 32'h100);
    tbl[8]  = mk(0, 0, 32'h0,   4'b0000, 3'b000, 0, 3'b000, 4'b1100, 32'hB, 32'h100);
    tbl[9]  = mk(0, 0, 32'h0,   4'b0000, 3'b000, 0, 3'b000, 4'b1010, 32'hB, 32'h100);
    tbl[10] = mk(0, 0, 32'h0,   4'b0000, 3'b000, 0, 3'b000, 4'b0000, 32'hB, 32'h100);
    // holdoff cycle blocks the interrupt, next cycle takes external
    tbl[11] = mk(0, 1, 32'h200, 4'b0000, 3'b111, 1, 3'b111, 4'b0000, 32'hB, 32'h100);
    tbl[12] = mk(0, 1, 32'h200, 4'b0000, 3'b111, 1, 3'b111, 4'b1100, 32'h8000000B, 32'h200);
    tbl[13] = mk(0, 0, 32'h0,   4'b0000, 3'b000, 0, 3'b000, 4'b1100, 32'h8000000B, 32'h200);
    tbl[14] = mk(0, 0, 32'h0,   4'b0000, 3'b000, 0, 3'b000, 4'b1010, 32'h8000000B, 32'h200);
    tbl[15] = mk(0, 0, 32'h0,   4'b0000, 3'b000, 0, 3'b000, 4'b0000, 32'h8000000B, 32'h200);
    tbl[16] = mk(0, 0, 32'h0,   4'b0000, 3'b000, 0, 3'b000, 4'b0000, 32'h8000000B, 32'h200);
    // external disabled -> software wins
    tbl[17] = mk(0, 1, 32'h300, 4'b0000, 3'b111, 1, 3'b011, 4'b1100, 32'h80000003, 32'h300);
    tbl[18] = mk(0, 0, 32'h0,   4'b0000, 3'b000, 0, 3'b000, 4'b1100, 32'h80000003, 32'h300);
    tbl[19] = mk(0, 0, 32'h0,   4'b0000, 3'b000, 0, 3'b000, 4'b1010, 32'h80000003, 32'h300);
    tbl[20] = mk(0, 0, 32'h0,   4'b0000, 3'b000, 0, 3'b000, 4'b0000, 32'h80000003, 32'h300);
    tbl[21] = mk(0, 0, 32'h0,   4'b0000, 3'b000, 0, 3'b000, 4'b0000, 32'h80000003, 32'h300);
    // illegal + mret + eligible external -> illegal, no return strobe
    tbl[22] = mk(0, 1, 32'h400, 4'b1001, 3'b100, 1, 3'b100, 4'b1100, 32'h2, 32'h400);
    tbl[23] = mk(0, 0, 32'h0,   4'b0000, 3'b000, 0, 3'b000, 4'b1100, 32'h2, 32'h400);
    tbl[24] = mk(0, 0, 32'h0,   4'b0000, 3'b000, 0, 3'b000, 4'b1010, 32'h2, 32'h400);
    tbl[25] = mk(0, 0, 32'h0,   4'b0000, 3'b000, 0, 3'b000, 4'b0000, 32'h2, 32'h400);

    #1;
    for (int i = 0; i < 26; i++) begin
      drive(tbl[i].rst, tbl[i].ce, tbl[i].pc, tbl[i].req, tbl[i].irq, tbl[i].mie, tbl[i].en);
      tick($sformatf("tbl%0d", i));
      cmp($sformatf("tbl%0d", i), 96'(dut_vec()), 96'({tbl[i].ctl, tbl[i].cause, tbl[i].epc}));
    end

    // Masked timer interrupt is never taken.
    drive(0, 1, 32'h600, 4'b0000, 3'b001, 0, 3'b001);
    for (int i = 0; i < 10; i++) begin
      tick("mask");
      cmp("mask_stall", 96'(o_stall), 96'(0));
    end
    // mret, then MIE rises; interrupt waits out the holdoff cycle.
    drive(0, 1, 32'h600, 4'b0001, 3'b001, 0, 3'b001);
    tick("mret");
    cmp("mret_ctl", 96'({o_stall, o_flush, o_go_to_trap, o_return_from_trap}), 96'(4'b1101));
    drive(0, 1, 32'h604, 4'b0000, 3'b001, 1, 3'b001);
    tick("mret_end");
    cmp("mret_end_ctl", 96'({o_stall, o_flush, o_go_to_trap, o_return_from_trap}), 96'(4'b0000));
    tick("holdoff");
    cmp("holdoff_ctl", 96'({o_stall, o_flush, o_go_to_trap, o_return_from_trap}), 96'(4'b0000));
    tick("timer_take");
    cmp("timer_take", 96'({o_stall, o_flush, o_mcause, o_mepc}), 96'({2'b11, 32'h80000007, 32'h604}));
    drive(0, 0, 32'h0, 4'b0000, 3'b000, 0, 3'b000);
    for (int i = 0; i < FC + 2; i++) tick("timer_drain");

    // Reset in the first DRAIN cycle aborts the trap.
    drive(0, 1, 32'h500, 4'b0010, 3'b000, 0, 3'b000);
    tick("ebreak");
    cmp("ebreak_acc", 96'({o_stall, o_flush, o_mcause}), 96'({2'b11, 32'h3}));
    drive(1, 0, 32'h0, 4'b0000, 3'b000, 0, 3'b000);
    tick("midrst");
    cmp("midrst_out", 96'(dut_vec()), 96'(0));
    drive(0, 0, 32'h0, 4'b0000, 3'b000, 0, 3'b000);
    for (int i = 0; i < FC + 4; i++) begin
      tick("postrst");
      cmp("postrst_trap", 96'(o_go_to_trap), 96'(0));
    end

    // Random stimulus against the model.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, $urandom,
            {$urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
             $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0},
            3'($urandom), $urandom_range(0, 3) != 0, 3'($urandom));
      tick("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
